// File: rtl/fetch_decode.sv
// Instruction fetch with a one-entry IR plus one-entry skid buffer, feeding field decode.
// Optional performance counters are enabled by defining FETCH_DECODE_PERF_EN.
module fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [4:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [16:0] entrada,
    output logic [17:0] entIn,
    output logic        sel
`ifdef FETCH_DECODE_PERF_EN
    ,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_stalls
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic [31:0] sk_data;
    logic [31:0] sk_pc;
    logic        sk_valid;

    logic        redirect;
    logic        ack_take;
    logic        to_ir;

    // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        redirect = flush | branch_taken;
        ack_take = (state == REQ) && imem_ack && !redirect;
        to_ir    = !ir_valid || !stall;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            ir_data   <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            sk_data   <= '0;
            sk_pc     <= '0;
            sk_valid  <= 1'b0;
        end else begin
            // Instruction holding: redirect kills everything, else IR/SK advance.
            if (redirect) begin
                ir_valid <= 1'b0;
                sk_valid <= 1'b0;
            end else if (ack_take) begin
                if (to_ir) begin
                    ir_data  <= imem_data;
                    ir_pc    <= imem_addr;
                    ir_valid <= 1'b1;
                end else begin
                    sk_data  <= imem_data;
                    sk_pc    <= imem_addr;
                    sk_valid <= 1'b1;
                end
            end else if (!stall) begin
                if (sk_valid) begin
                    ir_data  <= sk_data;
                    ir_pc    <= sk_pc;
                    ir_valid <= 1'b1;
                    sk_valid <= 1'b0;
                end else begin
                    ir_valid <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (branch_taken) begin
                        pc        <= branch_target;
                        imem_addr <= branch_target;
                    end else if (!flush && !(ir_valid && stall)) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        if (branch_taken) pc <= branch_target;
                        if (imem_ack) begin
                            state     <= IDLE;
                            imem_req  <= 1'b0;
                            imem_addr <= branch_taken ? branch_target : pc;
                        end else begin
                            // Address stays put until the outstanding request is answered.
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc        <= pc + 32'd4;
                        imem_addr <= pc + 32'd4;
                        if (!to_ir) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (branch_taken) pc <= branch_target;
                    if (imem_ack) begin
                        state     <= IDLE;
                        imem_req  <= 1'b0;
                        imem_addr <= branch_taken ? branch_target : pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_DECODE_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetches <= '0;
            perf_stalls  <= '0;
        end else begin
            if (ack_take) perf_fetches <= perf_fetches + 32'd1;
            if (stall && ir_valid) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

    assign instr_valid = ir_valid;
    assign pc_out      = ir_pc;
    assign opcode      = ir_data[31:27];
    assign rd          = ir_data[26:22];
    assign rs          = ir_data[21:17];
    assign rt          = ir_data[16:12];
    assign entrada     = ir_data[16:0];
    assign entIn       = ir_data[17:0];
    assign sel         = ir_data[31];

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: memory model, scoreboard of accepted fetches.
module tb_fetch_decode;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MEM_LAT  = 1;

    logic        clock = 1'b0;
    logic        reset, stall, flush, branch_taken;
    logic [31:0] branch_target;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_data;
    logic        instr_valid, sel;
    logic [31:0] pc_out;
    logic [4:0]  opcode, rd, rs, rt;
    logic [16:0] entrada;
    logic [17:0] entIn;
`ifdef FETCH_DECODE_PERF_EN
    logic [31:0] perf_fetches, perf_stalls;
`endif

    fetch_decode #(.RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .pc_out(pc_out), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
        .entrada(entrada), .entIn(entIn), .sel(sel)
`ifdef FETCH_DECODE_PERF_EN
        , .perf_fetches(perf_fetches), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t      sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] last_addr;
    logic [31:0] held_pc;
    bit          drop_next, use_fixed, ack_last, found;
    int          mem_cnt, exp_fetches, exp_stalls;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return use_fixed ? 32'h8000_0005 : ((a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F);
    endfunction

    function automatic logic [55:0] fields_of(input logic [31:0] d);
        return {d[31:27], d[26:22], d[21:17], d[16:12], d[16:0], d[17:0], d[31]};
    endfunction

    task automatic wait_neg();
        @(negedge clock);
        if (ack_last) begin
            check("latency_valid", {63'd0, instr_valid}, 64'd1);
            check("latency_pc", {32'd0, pc_out}, {32'd0, last_addr});
        end
        ack_last = 1'b0;
    endtask

    // Drive one cycle of inputs; memory model and scoreboard react to the current DUT outputs.
    task automatic apply(input bit st, input bit fl, input bit br, input logic [31:0] tgt,
                         input bit rs_i, input bit stray);
        entry_t e;
        bit red;
        red = fl | br;
        stall = st; flush = fl; branch_taken = br; branch_target = tgt; reset = rs_i;
        imem_ack = 1'b0;
        if (rs_i) begin
            sb.delete();
            drop_next = 1'b0; mem_cnt = 0; exp_pc = RESET_PC;
            exp_fetches = 0; exp_stalls = 0; ack_last = 1'b0;
            return;
        end
        if (st && instr_valid) exp_stalls++;
        if (instr_valid && !st && !red) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("sb_pc", {32'd0, pc_out}, {32'd0, e.addr});
                check("sb_fields", {8'd0, opcode, rd, rs, rt, entrada, entIn, sel},
                      {8'd0, fields_of(e.data)});
            end
        end
        if (stray) begin
            imem_ack  = 1'b1;
            imem_data = 32'hDEAD_BEEF;
        end else if (imem_req) begin
            if (mem_cnt == MEM_LAT) begin
                imem_ack  = 1'b1;
                imem_data = mem_word(imem_addr);
                mem_cnt   = 0;
                if (red || drop_next) begin
                    drop_next = 1'b0;
                end else begin
                    check("fetch_addr", {32'd0, imem_addr}, {32'd0, exp_pc});
                    e.addr = exp_pc;
                    e.data = mem_word(exp_pc);
                    sb.push_back(e);
                    exp_fetches++;
                    if (!st) begin
                        ack_last  = 1'b1;
                        last_addr = exp_pc;
                    end
                    exp_pc = exp_pc + 32'd4;
                end
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
        if (red) begin
            sb.delete();
            if (br) exp_pc = tgt;
            if (imem_req && !imem_ack) drop_next = 1'b1;
            ack_last = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            wait_neg();
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
    endtask

    // kind 0: IR valid; 1: request outstanding, no ack this cycle; 2: ack due this cycle.
    task automatic seek(input int kind, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_neg();
            case (kind)
                0:       ok = instr_valid;
                1:       ok = imem_req && (mem_cnt < MEM_LAT);
                default: ok = imem_req && (mem_cnt == MEM_LAT);
            endcase
            if (ok) break;
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        check(tag, {63'd0, ok}, 64'd1);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_ack = 1'b0; imem_data = '0;
        use_fixed = 1'b1; exp_pc = RESET_PC; drop_next = 1'b0; ack_last = 1'b0;
        mem_cnt = 0; exp_fetches = 0; exp_stalls = 0; last_addr = '0; held_pc = '0;

        // Reset state
        wait_neg(); apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        wait_neg();
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_addr", {32'd0, imem_addr}, {32'd0, RESET_PC});
        check("rst_pc_out", {32'd0, pc_out}, 64'd0);
        check("rst_fields", {8'd0, opcode, rd, rs, rt, entrada, entIn, sel}, 64'd0);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Sequential fetch of a constant word
        run(10);
        seek(0, "seek_valid_fixed", found);
        check("fixed_opcode", {59'd0, opcode}, 64'd16);
        check("fixed_sel", {63'd0, sel}, 64'd1);
        check("fixed_entIn", {46'd0, entIn}, 64'h5);
        check("fixed_entrada", {47'd0, entrada}, 64'h5);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Stall with IR valid while an ack lands in the skid buffer
        use_fixed = 1'b0;
        run(4);
        seek(0, "seek_valid_stall", found);
        held_pc = pc_out;
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_neg();
        check("stall_hold_pc1", {32'd0, pc_out}, {32'd0, held_pc});
        check("stall_hold_valid", {63'd0, instr_valid}, 64'd1);
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_neg();
        check("stall_hold_pc2", {32'd0, pc_out}, {32'd0, held_pc});
        check("sk_no_req1", {63'd0, imem_req}, 64'd0);
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_neg();
        check("stall_hold_pc3", {32'd0, pc_out}, {32'd0, held_pc});
        check("sk_no_req2", {63'd0, imem_req}, 64'd0);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_neg();
        check("sk_to_ir_valid", {63'd0, instr_valid}, 64'd1);
        check("sk_to_ir_pc", {32'd0, pc_out}, {32'd0, held_pc + 32'd4});
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        run(3);

        // Branch (with stall, to exercise priority) while a request is outstanding
        seek(1, "seek_req_branch", found);
        apply(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        wait_neg();
        check("br_kill_valid", {63'd0, instr_valid}, 64'd0);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_neg();
        check("br_drop_valid", {63'd0, instr_valid}, 64'd0);
        check("br_new_addr", {32'd0, imem_addr}, 64'h100);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        run(8);

        // Flush coincident with an ack: data dropped, PC kept
        seek(2, "seek_ack_flush", found);
        apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_neg();
        check("flush_valid", {63'd0, instr_valid}, 64'd0);
        check("flush_req", {63'd0, imem_req}, 64'd0);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        run(6);

        // PC wrap at the top of the address space
        wait_neg();
        apply(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        run(10);

        // Reset in the middle of a request, then a stray ack
        seek(1, "seek_req_reset", found);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        wait_neg();
        check("midrst_req", {63'd0, imem_req}, 64'd0);
        check("midrst_valid", {63'd0, instr_valid}, 64'd0);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_neg();
        check("stray_valid", {63'd0, instr_valid}, 64'd0);
        check("stray_req", {63'd0, imem_req}, 64'd1);
        check("stray_addr", {32'd0, imem_addr}, {32'd0, RESET_PC});
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        run(8);

        // Two stall cycles for the counters
        seek(0, "seek_valid_perf", found);
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_neg();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        run(6);
        wait_neg();
`ifdef FETCH_DECODE_PERF_EN
        check("perf_fetches", {32'd0, perf_fetches}, 64'(exp_fetches));
        check("perf_stalls", {32'd0, perf_stalls}, 64'(exp_stalls));
`endif
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
